// File: rtl/nd_packet_reader.sv
// Read side of the transmitter's non-data packet FIFO: validates the PID at the
// FIFO head, prepends SYNC, and streams handshake/token packets to the encoder.
module nd_packet_reader #(
    parameter logic [7:0]  SYNC_BYTE  = 8'h80,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_r_enable,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       pid_err,
    output logic       underrun,
    output logic       busy
);

    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SYNC,
        S_PID,
        S_TOK1,
        S_TOK2,
        S_EOP,
        S_GAP
    } state_e;

    typedef enum logic [1:0] {
        PID_ILLEGAL,
        PID_SHORT,
        PID_LONG
    } pid_class_e;

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             long_q, long_d;
    pid_class_e       pid_class;

    // Handshake PIDs carry no payload; token PIDs carry two more bytes.
    function automatic pid_class_e classify(input logic [7:0] pid);
        pid_class_e cls;
        case (pid)
            8'hD2, 8'h5A, 8'h1E:         cls = PID_SHORT;
            8'hE1, 8'h69, 8'h2D, 8'hA5:  cls = PID_LONG;
            default:                     cls = PID_ILLEGAL;
        endcase
        return cls;
    endfunction

    assign pid_class = classify(fifo_rdata);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        long_d        = long_q;
        fifo_r_enable = 1'b0;
        tx_data       = 8'h00;
        tx_valid      = 1'b0;
        tx_sop        = 1'b0;
        tx_eop        = 1'b0;
        pid_err       = 1'b0;
        underrun      = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_CHECK;
                end
            end

            // Legal PIDs stay at the head until sent; illegal ones are dropped here.
            S_CHECK: begin
                if (!fifo_empty && (pid_class != PID_ILLEGAL)) begin
                    long_d  = (pid_class == PID_LONG);
                    state_d = S_SYNC;
                end else begin
                    fifo_r_enable = !fifo_empty;
                    pid_err       = !fifo_empty;
                    state_d       = S_IDLE;
                end
            end

            S_SYNC: begin
                tx_data  = SYNC_BYTE;
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                if (tx_ready) begin
                    state_d = S_PID;
                end
            end

            // PID and token bytes share one path; a missing byte aborts the packet.
            S_PID, S_TOK1, S_TOK2: begin
                if (fifo_empty) begin
                    underrun = 1'b1;
                    state_d  = S_EOP;
                end else begin
                    tx_data  = fifo_rdata;
                    tx_valid = 1'b1;
                    if (tx_ready) begin
                        fifo_r_enable = 1'b1;
                        case (state_q)
                            S_PID:   state_d = long_q ? S_TOK1 : S_EOP;
                            S_TOK1:  state_d = S_TOK2;
                            default: state_d = S_EOP;
                        endcase
                    end
                end
            end

            S_EOP: begin
                tx_eop  = 1'b1;
                gap_d   = GAP_W'(GAP_CYCLES);
                state_d = S_GAP;
            end

            // Inter-packet gap: FIFO is ignored until the counter expires.
            S_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nd_packet_reader.sv
// Scoreboard bench for nd_packet_reader: a behavioural show-ahead FIFO feeds the
// DUT, expectations are queued by the stimulus and popped by a negedge monitor.
module tb_nd_packet_reader;

    localparam int EV_PIDERR   = 1;
    localparam int EV_UNDERRUN = 2;
    localparam int EV_EOP      = 3;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_r_enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;
    logic       pid_err;
    logic       underrun;
    logic       busy;

    logic [7:0] fifo_q[$];
    logic [8:0] exp_tx[$];
    logic [7:0] exp_pop[$];
    int         exp_evt[$];

    int         checks  = 0;
    int         errors  = 0;
    int         pop_cnt = 0;
    logic       pop_pend  = 1'b0;
    logic       hold_prev = 1'b0;
    logic [8:0] hold_word = '0;

    nd_packet_reader #(.SYNC_BYTE(8'h80), .GAP_CYCLES(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_r_enable(fifo_r_enable),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .pid_err      (pid_err),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic fifo_write(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic expect_evt(input int code, input string name);
        if (exp_evt.size() == 0) check({name, "_unexpected"}, 1, 0);
        else check(name, code, exp_evt.pop_front());
    endtask

    // FIFO model: the pop decided during the previous cycle takes effect just after the edge.
    always @(posedge clk) begin
        logic do_pop;
        do_pop = pop_pend && n_rst;
        #1;
        if (do_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            refresh();
        end
    end

    // Monitor: compares every presented byte, pop and pulse against the queues.
    always @(negedge clk) begin
        if (!n_rst) begin
            hold_prev = 1'b0;
            pop_pend  = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", tx_valid, 1);
                check("hold_word", {tx_sop, tx_data}, hold_word);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) check("tx_unexpected", {tx_sop, tx_data}, 9'h1FF);
                else check("tx_byte", {tx_sop, tx_data}, exp_tx.pop_front());
            end
            if (fifo_r_enable) begin
                check("pop_nonempty", fifo_empty, 0);
                if (exp_pop.size() == 0) check("pop_unexpected", fifo_rdata, 9'h1FF);
                else check("pop_byte", fifo_rdata, exp_pop.pop_front());
                pop_cnt++;
            end
            pop_pend = fifo_r_enable;
            if (pid_err)  expect_evt(EV_PIDERR, "evt_pid_err");
            if (underrun) expect_evt(EV_UNDERRUN, "evt_underrun");
            if (tx_eop)   expect_evt(EV_EOP, "evt_eop");
            hold_prev = tx_valid && !tx_ready;
            hold_word = {tx_sop, tx_data};
        end
    end

    task automatic wait_eop();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_eop) seen = 1;
        end
        check("eop_seen", seen, 1);
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        check("valid_seen", seen, 1);
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        check("idle_seen", seen, 1);
    endtask

    task automatic send_pkt(input logic [7:0] b[$]);
        exp_tx.push_back({1'b1, 8'h80});
        foreach (b[i]) begin
            exp_tx.push_back({1'b0, b[i]});
            exp_pop.push_back(b[i]);
            fifo_write(b[i]);
        end
        exp_evt.push_back(EV_EOP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0;
        bit         seen;
        logic [7:0] in_tok[$];
        logic [7:0] pkt[$];

        n_rst    = 1'b0;
        tx_ready = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {fifo_r_enable, tx_valid, tx_sop, tx_eop, pid_err, underrun, busy}, 0);
        check("reset_tx_data", tx_data, 8'h00);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // ACK with ready held high; also checks latency and gap length.
        tx_ready = 1'b1;
        p0 = pop_cnt;
        pkt = '{8'hD2};
        send_pkt(pkt);
        @(negedge clk); check("lat_idle", tx_valid, 0);
        @(negedge clk); check("lat_check_valid", tx_valid, 0);
        check("lat_check_busy", busy, 1);
        @(negedge clk); check("lat_sync", {tx_valid, tx_sop, tx_data}, {2'b11, 8'h80});
        wait_eop();
        @(negedge clk); check("gap1_busy", busy, 1);
        @(negedge clk); check("gap2_busy", busy, 1);
        @(negedge clk); check("gap_done_busy", busy, 0);
        check("ack_pops", pop_cnt - p0, 1);

        // IN token streamed back to back.
        @(posedge clk); #1;
        p0 = pop_cnt;
        in_tok = '{8'h69, 8'h81, 8'hA0};
        send_pkt(in_tok);
        wait_valid();
        foreach (in_tok[i]) begin
            @(negedge clk);
            check("in_stream", {tx_valid, tx_data}, {1'b1, in_tok[i]});
        end
        wait_eop();
        check("in_fifo_empty", fifo_empty, 1);
        check("in_pops", pop_cnt - p0, 3);
        wait_idle();

        // Illegal PID dropped, then a NAK packet.
        @(posedge clk); #1;
        p0 = pop_cnt;
        exp_pop.push_back(8'hC3);
        exp_evt.push_back(EV_PIDERR);
        fifo_write(8'hC3);
        pkt = '{8'h5A};
        send_pkt(pkt);
        wait_eop();
        check("nak_pops", pop_cnt - p0, 2);
        wait_idle();

        // IN token with the encoder stalling three cycles on every byte.
        @(posedge clk); #1;
        tx_ready = 1'b0;
        p0 = pop_cnt;
        in_tok = '{8'h69, 8'h3C, 8'h07};
        send_pkt(in_tok);
        for (int k = 0; k < 4; k++) begin
            wait_valid();
            repeat (3) @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        wait_eop();
        check("slow_pops", pop_cnt - p0, 3);
        wait_idle();

        // OUT token missing its last byte: underrun then abort eop.
        @(posedge clk); #1;
        tx_ready = 1'b1;
        p0 = pop_cnt;
        exp_tx.push_back({1'b1, 8'h80});
        exp_tx.push_back({1'b0, 8'hE1});
        exp_tx.push_back({1'b0, 8'h01});
        exp_pop.push_back(8'hE1);
        exp_pop.push_back(8'h01);
        exp_evt.push_back(EV_UNDERRUN);
        exp_evt.push_back(EV_EOP);
        fifo_write(8'hE1);
        fifo_write(8'h01);
        wait_eop();
        check("under_pops", pop_cnt - p0, 2);
        check("under_fifo_empty", fifo_empty, 1);
        wait_idle();

        // Reset while a SETUP token byte is waiting in TOK1.
        @(posedge clk); #1;
        p0 = pop_cnt;
        exp_tx.push_back({1'b1, 8'h80});
        exp_tx.push_back({1'b0, 8'h2D});
        exp_pop.push_back(8'h2D);
        fifo_write(8'h2D);
        fifo_write(8'h00);
        fifo_write(8'h10);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid && !tx_sop && tx_data == 8'h2D) seen = 1;
        end
        check("setup_pid_seen", seen, 1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check("tok1_offer", {tx_valid, tx_data}, {1'b1, 8'h00});
        #2 n_rst = 1'b0;
        #1;
        check("rst_async_outs", {fifo_r_enable, tx_valid, tx_sop, tx_eop, pid_err, underrun, busy}, 0);
        check("rst_async_data", tx_data, 8'h00);
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_fifo_left", fifo_q.size(), 2);
        check("rst_fifo_head", fifo_rdata, 8'h00);
        check("rst_pops", pop_cnt - p0, 1);
        exp_pop.push_back(8'h00);
        exp_pop.push_back(8'h10);
        exp_evt.push_back(EV_PIDERR);
        exp_evt.push_back(EV_PIDERR);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_empty", fifo_empty, 1);
        check("post_rst_idle", busy, 0);

        repeat (3) @(negedge clk);
        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_pop_drained", exp_pop.size(), 0);
        check("exp_evt_drained", exp_evt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
